latch_write_sequencer: RTL and testbench
========================================

Name: latch_write_sequencer

Overview:
Synchronous front end that drives the data and write-enable inputs of the gated D latch (d, wen) and reads back its q.
- Accepts one write request at a time over a valid/ready handshake.
- Sequences latch data setup, the enable pulse and the hold interval with registered, glitch-free outputs.
- Samples q after the hold interval and reports completion with a pass/fail flag.

Parameters:
- WIDTH, 1: bits per write; one gated D latch per bit, driven in parallel.
- SETUP_CYC, 1: cycles lat_d is stable before lat_we rises. Must be >=1.
- PULSE_CYC, 2: cycles lat_we is held high. Must be >=1.
- HOLD_CYC, 1: cycles lat_d is held after lat_we falls. Must be >=1.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- req_valid  in  1  write request present.
- req_ready  out  1  sequencer can accept a request.
- req_data  in  WIDTH  value to write.
- lat_d  out  WIDTH  to latch d inputs.
- lat_we  out  1  to latch wen inputs.
- lat_q  in  WIDTH  from latch q outputs (readback).
- done_valid  out  1  one-cycle completion pulse.
- done_err  out  1  readback mismatch; qualified by done_valid.

Behaviour:
- Reset (rst_n low, asynchronous; clears immediately, including mid-sequence):
  - state=IDLE, counter=0.
  - lat_we=0, lat_d=0, req_ready=1, done_valid=0, done_err=0.
  - The latch keeps whatever value it held; no recovery write is issued.
- All outputs come straight from flops. No combinational path from any input to any output.
- FSM states: IDLE, SETUP, PULSE, HOLD, CHECK.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1: capture req_data into lat_d, load counter=SETUP_CYC-1, req_ready<=0, go to SETUP.
- SETUP:
  - lat_we=0 and lat_d stable.
  - While counter!=0, decrement.
  - At counter==0: lat_we<=1, counter<=PULSE_CYC-1, go to PULSE.
- PULSE:
  - lat_we=1.
  - At counter==0: lat_we<=0, counter<=HOLD_CYC-1, go to HOLD.
- HOLD:
  - lat_we=0 and lat_d unchanged.
  - At counter==0, go to CHECK.
- CHECK (exactly one cycle):
  - Compare lat_q against lat_d.
  - At the edge: done_valid<=1, done_err<=(lat_q!=lat_d), req_ready<=1, go to IDLE.
- done_valid is high for exactly one cycle, and that cycle coincides with the first cycle of req_ready=1.
- Timing from accept edge E0:
  - lat_we rises at E0+SETUP_CYC and falls at E0+SETUP_CYC+PULSE_CYC.
  - done_valid rises at E0+SETUP_CYC+PULSE_CYC+HOLD_CYC+1.
  - Defaults: lat_we high E0+1 to E0+3; done at E0+5; throughput one write per 6 cycles.
- lat_d changes only on an accept edge. It never changes while lat_we=1 or during HOLD.
- Requests are not accepted outside IDLE. req_valid asserted while busy is held off by req_ready=0; the request is not dropped.
- A request is accepted on the same edge that done_valid is asserted only if req_ready was 1 in the previous cycle. That never happens, so back-to-back writes have one idle cycle in which done_valid=1 and req_ready=1.
- A request present during the done_valid cycle is accepted at that cycle's closing edge.
- Counter width: clog2(max(SETUP_CYC,PULSE_CYC,HOLD_CYC)+1), minimum 1 bit.
- lat_q is sampled only in CHECK. Its value is don't-care in all other states.

Decomposition:
- Shared package latch_seq_pkg:
  - state enum {IDLE, SETUP, PULSE, HOLD, CHECK}.
  - Default timing localparams.
  - Counter-width function.
- One natural sub-module, lws_cycle_counter: loadable down-counter with load value input, load enable and zero flag. Reused for all three intervals.

Test Plan:
1. Reset then idle (WIDTH=1): rst_n low 3 cycles, then high -> lat_we=0, lat_d=0, req_ready=1, done_valid=0 throughout; no latch activity.
2. Single write of 1, defaults: req_valid=1, req_data=1 at E0 -> lat_d=1 from E0, lat_we=1 exactly E0+1..E0+3, done_valid=1 at E0+5 with done_err=0, latch q=1 and qbar=0 thereafter.
3. Back-to-back writes 1 then 0, req_valid held high: second accept at E0+6 -> lat_d stays 1 until E0+6, latch q=1 then q=0, two done pulses 6 cycles apart, both with done_err=0.
4. Forced mismatch: tie lat_q to 0, write 1 -> done_valid at E0+5 with done_err=1; next write of 0 -> done_err=0.
5. Reset mid-pulse: assert rst_n low at E0+2 while lat_we=1 -> lat_we falls at once (before next clk edge), state IDLE, no done_valid; after release req_ready=1 and a new write completes normally.
6. Timing sweep: SETUP_CYC=3, PULSE_CYC=1, HOLD_CYC=2, WIDTH=4, write 4'hA -> lat_we high only at E0+3, done_valid at E0+7, done_err=0, q=4'hA.

Source files
------------

// File: rtl/latch_seq_pkg.sv
// Shared types, default timing and helpers for the gated-latch write sequencer.
package latch_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    CHECK
  } state_t;

  localparam int unsigned DEF_WIDTH     = 1;
  localparam int unsigned DEF_SETUP_CYC = 1;
  localparam int unsigned DEF_PULSE_CYC = 2;
  localparam int unsigned DEF_HOLD_CYC  = 1;

  // Bits needed to hold the largest interval count; never fewer than one.
  function automatic int unsigned cnt_width(input int unsigned s, input int unsigned p,
                                            input int unsigned h);
    int unsigned m;
    int unsigned w;
    m = s;
    if (p > m) m = p;
    if (h > m) m = h;
    w = $clog2(m + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/lws_cycle_counter.sv
// Loadable down-counter shared by the setup, pulse and hold intervals.
module lws_cycle_counter #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Load wins over decrement; decrement saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/latch_write_sequencer.sv
// Sequences data setup, enable pulse and hold for a bank of gated D latches,
// then reads q back and reports completion with a mismatch flag.
module latch_write_sequencer
  import latch_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
  parameter int unsigned PULSE_CYC = DEF_PULSE_CYC,
  parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  output logic [WIDTH-1:0] lat_d,
  output logic             lat_we,
  input  logic [WIDTH-1:0] lat_q,
  output logic             done_valid,
  output logic             done_err
);

  localparam int unsigned CW = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);

  state_t           state, state_nx;
  logic [WIDTH-1:0] d_nx;
  logic             we_nx, ready_nx, done_nx, err_nx;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0]    cnt_load_value;

  lws_cycle_counter #(
    .W(CW)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cnt_load),
    .load_value(cnt_load_value),
    .dec       (cnt_dec),
    .zero      (cnt_zero)
  );

  // Every output is computed one cycle ahead so it can leave straight from a flop.
  always_comb begin
    state_nx       = state;
    d_nx           = lat_d;
    we_nx          = lat_we;
    ready_nx       = req_ready;
    done_nx        = 1'b0;
    err_nx         = 1'b0;
    cnt_load       = 1'b0;
    cnt_dec        = 1'b0;
    cnt_load_value = '0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          d_nx           = req_data;
          cnt_load       = 1'b1;
          cnt_load_value = CW'(SETUP_CYC - 1);
          ready_nx       = 1'b0;
          state_nx       = SETUP;
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          we_nx          = 1'b1;
          cnt_load       = 1'b1;
          cnt_load_value = CW'(PULSE_CYC - 1);
          state_nx       = PULSE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      PULSE: begin
        if (cnt_zero) begin
          we_nx          = 1'b0;
          cnt_load       = 1'b1;
          cnt_load_value = CW'(HOLD_CYC - 1);
          state_nx       = HOLD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          state_nx = CHECK;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      CHECK: begin
        done_nx  = 1'b1;
        err_nx   = (lat_q != lat_d);
        ready_nx = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        we_nx    = 1'b0;
        ready_nx = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lat_d      <= '0;
      lat_we     <= 1'b0;
      req_ready  <= 1'b1;
      done_valid <= 1'b0;
      done_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      lat_d      <= d_nx;
      lat_we     <= we_nx;
      req_ready  <= ready_nx;
      done_valid <= done_nx;
      done_err   <= err_nx;
    end
  end

endmodule

// File: tb/tb_latch_write_sequencer.sv
// Bench for latch_write_sequencer: behavioural latches on lat_d/lat_we, a vector
// table, hand-written corner sequences and a random run against a timing model.
module tb_latch_write_sequencer;

  localparam int unsigned S = 1, P = 2, H = 1;
  localparam int DONE_K = S + P + H + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // default instance, WIDTH=1
  logic       req_valid, req_ready, lat_we, done_valid, done_err;
  logic [0:0] req_data, lat_d, lat_q, mask;
  logic [0:0] q_model = 1'b0;

  // swept-timing instance
  logic       req_valid6, req_ready6, lat_we6, done_valid6, done_err6;
  logic [3:0] req_data6, lat_d6, lat_q6;
  logic [3:0] q_model6 = 4'h0;

  always @(lat_we or lat_d) if (lat_we) q_model = lat_d;
  always @(lat_we6 or lat_d6) if (lat_we6) q_model6 = lat_d6;
  assign lat_q  = q_model ^ mask;
  assign lat_q6 = q_model6;

  latch_write_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .lat_d(lat_d), .lat_we(lat_we), .lat_q(lat_q),
    .done_valid(done_valid), .done_err(done_err)
  );

  latch_write_sequencer #(
    .WIDTH(4), .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)
  ) dut6 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid6), .req_ready(req_ready6),
    .req_data(req_data6), .lat_d(lat_d6), .lat_we(lat_we6), .lat_q(lat_q6),
    .done_valid(done_valid6), .done_err(done_err6)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic v, dat, m;
    logic rdy, we, dn, er, d, q;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic v, input logic dat, input logic m,
                              input logic rdy, input logic we, input logic dn,
                              input logic er, input logic d, input logic q);
    vec_t r;
    r.v = v; r.dat = dat; r.m = m;
    r.rdy = rdy; r.we = we; r.dn = dn; r.er = er; r.d = d; r.q = q;
    tbl.push_back(r);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int   n, t0, cyc, k;
    bit   m_ready;
    logic m_data, m_mask;

    rst_n = 1'b0; req_valid = 1'b0; req_data = '0; mask = '0;
    req_valid6 = 1'b0; req_data6 = '0;

    // reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_we", lat_we, 0); chk("rst_ready", req_ready, 1);
      chk("rst_done", done_valid, 0); chk("rst_d", lat_d, 0);
    end
    rst_n = 1'b1;

    //  v dat m | rdy we dn er d q
    add(0,0,0, 1,0,0,0,0,0); add(0,0,0, 1,0,0,0,0,0);
    // single write of 1
    add(1,1,0, 0,0,0,0,1,0); add(0,0,0, 0,1,0,0,1,1); add(0,0,0, 0,1,0,0,1,1);
    add(0,0,0, 0,0,0,0,1,1); add(0,0,0, 0,0,0,0,1,1); add(0,0,0, 1,0,1,0,1,1);
    add(0,0,0, 1,0,0,0,1,1);
    // back-to-back 1 then 0, valid held high
    add(1,1,0, 0,0,0,0,1,1); add(1,0,0, 0,1,0,0,1,1); add(1,0,0, 0,1,0,0,1,1);
    add(1,0,0, 0,0,0,0,1,1); add(1,0,0, 0,0,0,0,1,1); add(1,0,0, 1,0,1,0,1,1);
    add(1,0,0, 0,0,0,0,0,1); add(0,0,0, 0,1,0,0,0,0); add(0,0,0, 0,1,0,0,0,0);
    add(0,0,0, 0,0,0,0,0,0); add(0,0,0, 0,0,0,0,0,0); add(0,0,0, 1,0,1,0,0,0);
    // readback forced to 0 (mask flips q=1): write 1 errs, then write 0 is clean
    add(1,1,1, 0,0,0,0,1,0); add(0,0,1, 0,1,0,0,1,1); add(0,0,1, 0,1,0,0,1,1);
    add(0,0,1, 0,0,0,0,1,1); add(0,0,1, 0,0,0,0,1,1); add(0,0,1, 1,0,1,1,1,1);
    add(1,0,0, 0,0,0,0,0,1); add(0,0,0, 0,1,0,0,0,0); add(0,0,0, 0,1,0,0,0,0);
    add(0,0,0, 0,0,0,0,0,0); add(0,0,0, 0,0,0,0,0,0); add(0,0,0, 1,0,1,0,0,0);

    foreach (tbl[i]) begin
      req_valid = tbl[i].v; req_data = tbl[i].dat; mask = tbl[i].m;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_we", i), lat_we, tbl[i].we);
      chk($sformatf("tbl%0d_done", i), done_valid, tbl[i].dn);
      if (tbl[i].dn) chk($sformatf("tbl%0d_err", i), done_err, tbl[i].er);
      chk($sformatf("tbl%0d_d", i), lat_d, tbl[i].d);
      chk($sformatf("tbl%0d_q", i), q_model, tbl[i].q);
    end
    req_valid = 1'b0; mask = '0;

    // reset asserted mid-pulse
    req_valid = 1'b1; req_data = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    chk("mid_we_before", lat_we, 1);
    rst_n = 1'b0; #1;
    chk("mid_we_async", lat_we, 0); chk("mid_ready_async", req_ready, 1);
    chk("mid_done_async", done_valid, 0); chk("mid_d_async", lat_d, 0);
    repeat (2) @(posedge clk);
    #1 chk("mid_done_held", done_valid, 0);
    @(negedge clk); rst_n = 1'b1;
    chk("mid_ready_after", req_ready, 1);
    req_valid = 1'b1; req_data = 1'b0;
    @(posedge clk); #1 req_valid = 1'b0;
    n = 0;
    while (!done_valid && n < 20) begin
      @(posedge clk); #1 n++;
    end
    chk("mid_latency", n, 5); chk("mid_err", done_err, 0); chk("mid_q", q_model, 0);

    // timing sweep instance S=3 P=1 H=2
    @(negedge clk);
    req_valid6 = 1'b1; req_data6 = 4'hA;
    @(posedge clk); #1 req_valid6 = 1'b0;
    for (int j = 0; j < 10; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
      chk($sformatf("sw%0d_we", j), lat_we6, (j == 3));
      chk($sformatf("sw%0d_done", j), done_valid6, (j == 7));
      chk($sformatf("sw%0d_d", j), lat_d6, 4'hA);
      if (j == 7) begin
        chk("sw_err", done_err6, 0); chk("sw_q", q_model6, 4'hA);
      end
    end

    // random run against a transaction-timing model
    do_reset();
    m_ready = 1'b1; m_data = 1'b0; m_mask = 1'b0; t0 = -1000; cyc = 0;
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 2) != 0);
      req_data  = 1'($urandom);
      if (m_ready) mask = 1'($urandom_range(0, 3) == 0);
      @(posedge clk);
      cyc++;
      if (m_ready && req_valid) begin
        t0 = cyc; m_data = req_data; m_mask = mask; m_ready = 1'b0;
      end else if (!m_ready && (cyc - t0 == DONE_K)) begin
        m_ready = 1'b1;
      end
      @(negedge clk);
      k = cyc - t0;
      chk("rnd_ready", req_ready, m_ready);
      chk("rnd_we", lat_we, (!m_ready && k >= S && k < S + P));
      chk("rnd_done", done_valid, (k == DONE_K));
      chk("rnd_d", lat_d, m_data);
      if (k == DONE_K) begin
        chk("rnd_err", done_err, m_mask);
        chk("rnd_q", q_model, m_data);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
